// File: rtl/mem_access_unit_pkg.sv
// Shared types and bus-geometry helpers for the load/store engine.
package mem_access_unit_pkg;

    typedef enum logic [1:0] {
        MSZ_B = 2'd0,
        MSZ_H = 2'd1,
        MSZ_W = 2'd2,
        MSZ_D = 2'd3
    } mem_size_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2,
        DONE  = 2'd3
    } mem_state_t;

    function automatic int bus_bytes(int xlen);
        return xlen / 8;
    endfunction

    function automatic int bus_ofs(int xlen);
        return $clog2(xlen / 8);
    endfunction

endpackage

// File: rtl/mem_access_unit_align.sv
// Combinational beat generation (address/size/strobe/lane data) and
// read-data merge with sign/zero extension.
module mem_align_unit
    import mem_access_unit_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0]           addr_i,
    input  logic [1:0]                size_i,
    input  logic [XLEN-1:0]           wdata_i,
    input  logic                      beat_i,
    input  logic [XLEN-1:0]           rlo_i,
    input  logic [XLEN-1:0]           rhi_i,
    input  logic                      unsigned_i,
    output logic                      aligned_o,
    output logic                      cross_o,
    output logic [XLEN-1:0]           baddr_o,
    output logic [2:0]                bsize_o,
    output logic [XLEN/8-1:0]         bstrobe_o,
    output logic [XLEN-1:0]           bdata_o,
    output logic [XLEN-1:0]           rdata_o
);
    localparam int BUS_BYTES = bus_bytes(XLEN);
    localparam int OFS       = bus_ofs(XLEN);

    logic [OFS-1:0]           off;
    logic [3:0]               nbytes;
    logic [2*BUS_BYTES-1:0]   mask_w, strb_w;
    logic [2*XLEN-1:0]        data_w, cat_w;
    logic [XLEN-1:0]          base, sval, keep, topbit;
    logic                     sgn;

    assign off       = addr_i[OFS-1:0];
    assign nbytes    = 4'd1 << size_i;
    assign aligned_o = (addr_i[2:0] & 3'(nbytes - 4'd1)) == 3'd0;
    assign cross_o   = ({1'b0, nbytes} + 5'(off)) > 5'(BUS_BYTES);

    // Shifting into a double-width window yields both beats at once:
    // the low half is beat 0, the spill-over high half is beat 1.
    assign mask_w = (2*BUS_BYTES)'((16'd1 << nbytes) - 16'd1);
    assign strb_w = mask_w << off;
    assign data_w = {{XLEN{1'b0}}, wdata_i} << {off, 3'b000};
    assign base   = {addr_i[XLEN-1:OFS], {OFS{1'b0}}};

    always_comb begin
        baddr_o   = base;
        bsize_o   = 3'(OFS);
        bstrobe_o = strb_w[BUS_BYTES-1:0];
        bdata_o   = data_w[XLEN-1:0];
        if (beat_i) begin
            baddr_o   = base + XLEN'(BUS_BYTES);
            bstrobe_o = strb_w[2*BUS_BYTES-1:BUS_BYTES];
            bdata_o   = data_w[2*XLEN-1:XLEN];
        end else if (aligned_o) begin
            baddr_o = addr_i;
            bsize_o = {1'b0, size_i};
        end
    end

    // A shift by the full width gives zero, so a dword keep-mask becomes all ones.
    assign cat_w   = {rhi_i, rlo_i} >> {off, 3'b000};
    assign sval    = cat_w[XLEN-1:0];
    assign keep    = (XLEN'(1) << {nbytes, 3'b000}) - XLEN'(1);
    assign topbit  = keep ^ (keep >> 1);
    assign sgn     = |(sval & topbit);
    assign rdata_o = (sval & keep) | ((sgn && !unsigned_i) ? ~keep : '0);

endmodule

// File: rtl/mem_access_unit.sv
// Load/store engine: accepts one access, drives one or two bus beats and
// reports a merged/extended load result, store completion or misalignment trap.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int XLEN             = 64,
    parameter bit SPLIT_MISALIGNED = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_kill,
    input  logic                 in_write,
    input  logic [XLEN-1:0]      in_addr,
    input  logic [1:0]           in_size,
    input  logic                 in_unsigned,
    input  logic [XLEN-1:0]      in_wdata,
    output logic                 dreq_valid,
    output logic [XLEN-1:0]      dreq_addr,
    output logic [2:0]           dreq_size,
    output logic [XLEN/8-1:0]    dreq_strobe,
    output logic [XLEN-1:0]      dreq_data,
    input  logic                 dresp_addr_ok,
    input  logic                 dresp_data_ok,
    input  logic [XLEN-1:0]      dresp_data,
    output logic                 out_valid,
    output logic [XLEN-1:0]      out_rdata,
    output logic                 out_misaligned,
    output logic                 out_is_store
);
    localparam int BUS_BYTES = bus_bytes(XLEN);

    mem_state_t             state_q;
    mem_size_t              size_q;
    logic [XLEN-1:0]        addr_q, wdata_q, rdata0_q, out_rdata_q;
    logic                   write_q, unsigned_q, cross_q, killed_q;
    logic                   dreq_valid_q, out_mis_q, out_st_q;
    logic [XLEN-1:0]        dreq_addr_q, dreq_data_q;
    logic [2:0]             dreq_size_q;
    logic [BUS_BYTES-1:0]   dreq_strobe_q;

    logic                   idle, accept, bus_hs, kill_now;
    logic [XLEN-1:0]        a_addr, a_wdata, a_rlo;
    logic [1:0]             a_size;
    logic                   al_aligned, al_cross;
    logic [XLEN-1:0]        al_baddr, al_bdata, al_rdata;
    logic [2:0]             al_bsize;
    logic [BUS_BYTES-1:0]   al_bstrobe;

    assign idle     = (state_q == IDLE);
    assign in_ready = idle && !in_kill;
    assign accept   = in_valid && in_ready;
    assign bus_hs   = dreq_valid_q && dresp_addr_ok && dresp_data_ok;
    assign kill_now = killed_q || in_kill;

    // Before acceptance the request fields are not yet latched, so look at the inputs.
    assign a_addr  = idle ? in_addr  : addr_q;
    assign a_size  = idle ? in_size  : size_q;
    assign a_wdata = idle ? in_wdata : wdata_q;
    assign a_rlo   = (state_q == BEAT1) ? rdata0_q : dresp_data;

    mem_align_unit #(.XLEN(XLEN)) u_align (
        .addr_i     (a_addr),
        .size_i     (a_size),
        .wdata_i    (a_wdata),
        .beat_i     (state_q == BEAT1),
        .rlo_i      (a_rlo),
        .rhi_i      (dresp_data),
        .unsigned_i (unsigned_q),
        .aligned_o  (al_aligned),
        .cross_o    (al_cross),
        .baddr_o    (al_baddr),
        .bsize_o    (al_bsize),
        .bstrobe_o  (al_bstrobe),
        .bdata_o    (al_bdata),
        .rdata_o    (al_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            size_q        <= MSZ_B;
            addr_q        <= '0;
            wdata_q       <= '0;
            rdata0_q      <= '0;
            write_q       <= 1'b0;
            unsigned_q    <= 1'b0;
            cross_q       <= 1'b0;
            killed_q      <= 1'b0;
            dreq_valid_q  <= 1'b0;
            dreq_addr_q   <= '0;
            dreq_size_q   <= '0;
            dreq_strobe_q <= '0;
            dreq_data_q   <= '0;
            out_rdata_q   <= '0;
            out_mis_q     <= 1'b0;
            out_st_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (accept) begin
                    addr_q     <= in_addr;
                    size_q     <= mem_size_t'(in_size);
                    wdata_q    <= in_wdata;
                    write_q    <= in_write;
                    unsigned_q <= in_unsigned;
                    cross_q    <= al_cross;
                    killed_q   <= 1'b0;
                    if (!al_aligned && !SPLIT_MISALIGNED) begin
                        state_q     <= DONE;
                        out_mis_q   <= 1'b1;
                        out_st_q    <= in_write;
                        out_rdata_q <= '0;
                    end else begin
                        state_q       <= BEAT0;
                        dreq_valid_q  <= 1'b1;
                        dreq_addr_q   <= al_baddr;
                        dreq_size_q   <= al_bsize;
                        dreq_strobe_q <= in_write ? al_bstrobe : '0;
                        dreq_data_q   <= in_write ? al_bdata : '0;
                    end
                end
                BEAT0: begin
                    if (in_kill) killed_q <= 1'b1;
                    if (bus_hs) begin
                        dreq_valid_q <= 1'b0;
                        rdata0_q     <= dresp_data;
                        if (kill_now) begin
                            state_q <= IDLE;
                        end else if (cross_q) begin
                            state_q <= BEAT1;
                        end else begin
                            state_q     <= DONE;
                            out_mis_q   <= 1'b0;
                            out_st_q    <= write_q;
                            out_rdata_q <= write_q ? '0 : al_rdata;
                        end
                    end
                end
                BEAT1: begin
                    // First cycle here is the mandatory bus gap; the second beat is raised after it.
                    if (!dreq_valid_q) begin
                        if (kill_now) begin
                            state_q <= IDLE;
                        end else begin
                            dreq_valid_q  <= 1'b1;
                            dreq_addr_q   <= al_baddr;
                            dreq_size_q   <= al_bsize;
                            dreq_strobe_q <= write_q ? al_bstrobe : '0;
                            dreq_data_q   <= write_q ? al_bdata : '0;
                        end
                    end else begin
                        if (in_kill) killed_q <= 1'b1;
                        if (bus_hs) begin
                            dreq_valid_q <= 1'b0;
                            if (kill_now) begin
                                state_q <= IDLE;
                            end else begin
                                state_q     <= DONE;
                                out_mis_q   <= 1'b0;
                                out_st_q    <= write_q;
                                out_rdata_q <= write_q ? '0 : al_rdata;
                            end
                        end
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign dreq_valid     = dreq_valid_q;
    assign dreq_addr      = dreq_addr_q;
    assign dreq_size      = dreq_size_q;
    assign dreq_strobe    = dreq_strobe_q;
    assign dreq_data      = dreq_data_q;
    assign out_valid      = (state_q == DONE) && !in_kill;
    assign out_rdata      = out_rdata_q;
    assign out_misaligned = out_mis_q;
    assign out_is_store   = out_st_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench: a split-mode and a trap-mode instance share stimulus, one selected at a time.
module tb_mem_access_unit;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        sel;
    logic        in_valid, in_kill, in_write, in_unsigned;
    logic [63:0] in_addr, in_wdata;
    logic [1:0]  in_size;
    logic        dresp_addr_ok, dresp_data_ok;
    logic [63:0] dresp_data;

    logic        rdy_s, dv_s, ov_s, omis_s, ost_s, rdy_t, dv_t, ov_t, omis_t, ost_t;
    logic [63:0] da_s, dd_s, ord_s, da_t, dd_t, ord_t;
    logic [2:0]  dsz_s, dsz_t;
    logic [7:0]  dst_s, dst_t;
    logic        vld_s, vld_t;

    assign vld_s = in_valid && !sel;
    assign vld_t = in_valid && sel;

    mem_access_unit #(.XLEN(64), .SPLIT_MISALIGNED(1'b1)) u_split (
        .clk(clk), .rst(rst), .in_valid(vld_s), .in_ready(rdy_s), .in_kill(in_kill),
        .in_write(in_write), .in_addr(in_addr), .in_size(in_size), .in_unsigned(in_unsigned),
        .in_wdata(in_wdata), .dreq_valid(dv_s), .dreq_addr(da_s), .dreq_size(dsz_s),
        .dreq_strobe(dst_s), .dreq_data(dd_s), .dresp_addr_ok(dresp_addr_ok),
        .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data), .out_valid(ov_s),
        .out_rdata(ord_s), .out_misaligned(omis_s), .out_is_store(ost_s));

    mem_access_unit #(.XLEN(64), .SPLIT_MISALIGNED(1'b0)) u_trap (
        .clk(clk), .rst(rst), .in_valid(vld_t), .in_ready(rdy_t), .in_kill(in_kill),
        .in_write(in_write), .in_addr(in_addr), .in_size(in_size), .in_unsigned(in_unsigned),
        .in_wdata(in_wdata), .dreq_valid(dv_t), .dreq_addr(da_t), .dreq_size(dsz_t),
        .dreq_strobe(dst_t), .dreq_data(dd_t), .dresp_addr_ok(dresp_addr_ok),
        .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data), .out_valid(ov_t),
        .out_rdata(ord_t), .out_misaligned(omis_t), .out_is_store(ost_t));

    logic        m_rdy, m_dv, m_ov, m_omis, m_ost;
    logic [63:0] m_da, m_dd, m_ord;
    logic [2:0]  m_dsz;
    logic [7:0]  m_dst;
    assign m_rdy  = sel ? rdy_t  : rdy_s;
    assign m_dv   = sel ? dv_t   : dv_s;
    assign m_ov   = sel ? ov_t   : ov_s;
    assign m_omis = sel ? omis_t : omis_s;
    assign m_ost  = sel ? ost_t  : ost_s;
    assign m_da   = sel ? da_t   : da_s;
    assign m_dd   = sel ? dd_t   : dd_s;
    assign m_ord  = sel ? ord_t  : ord_s;
    assign m_dsz  = sel ? dsz_t  : dsz_s;
    assign m_dst  = sel ? dst_t  : dst_s;

    int nchk = 0;
    int nfail = 0;

    // Results of the most recent access, filled by do_access.
    int          nb, pulses, out_cyc;
    logic        unstable, acc_rdy, o_mis, o_st;
    logic [63:0] o_rdata;
    logic [63:0] b_addr [4];
    logic [63:0] b_data [4];
    logic [2:0]  b_size [4];
    logic [7:0]  b_strb [4];
    logic        rdy_at [16];

    // Offers one access (accepted in cycle 0) and plays a bus with 'waits' stall cycles per beat.
    task automatic do_access(input logic s, input logic wr, input logic [63:0] addr,
                             input logic [1:0] size, input logic uns, input logic [63:0] wd,
                             input logic [63:0] d0, input logic [63:0] d1,
                             input int waits, input int kill_cyc);
        logic in_beat;
        int   wcnt;
        @(negedge clk);
        sel = s; in_valid = 1'b1; in_write = wr; in_addr = addr; in_size = size;
        in_unsigned = uns; in_wdata = wd; in_kill = 1'b0;
        #1 acc_rdy = m_rdy;
        @(negedge clk);
        in_valid = 1'b0;
        nb = 0; pulses = 0; out_cyc = -1; unstable = 1'b0; in_beat = 1'b0; wcnt = 0;
        o_rdata = '0; o_mis = 1'b0; o_st = 1'b0;
        for (int c = 1; c < 16; c++) begin
            in_kill = (c == kill_cyc);
            #1;
            rdy_at[c] = m_rdy;
            if (m_ov) begin
                if (pulses == 0) begin
                    out_cyc = c; o_rdata = m_ord; o_mis = m_omis; o_st = m_ost;
                end
                pulses++;
            end
            dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0; dresp_data = '0;
            if (m_dv) begin
                if (!in_beat) begin
                    in_beat = 1'b1; wcnt = 0;
                    if (nb < 4) begin
                        b_addr[nb] = m_da; b_data[nb] = m_dd; b_size[nb] = m_dsz; b_strb[nb] = m_dst;
                    end
                    nb++;
                end else if (nb <= 4 && (m_da !== b_addr[nb-1] || m_dd !== b_data[nb-1] ||
                                         m_dsz !== b_size[nb-1] || m_dst !== b_strb[nb-1])) begin
                    unstable = 1'b1;
                end
                if (wcnt >= waits) begin
                    dresp_addr_ok = 1'b1; dresp_data_ok = 1'b1;
                    dresp_data = (nb == 1) ? d0 : d1;
                    in_beat = 1'b0;
                end else begin
                    wcnt++;
                end
            end
            @(negedge clk);
        end
        in_kill = 1'b0;
        dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0; dresp_data = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #12;
        nchk++; if (m_dv !== 1'b0) begin nfail++; $display("FAIL reset_dreq_valid got %b exp 0", m_dv); end
        nchk++; if (m_da !== 64'h0 || m_dd !== 64'h0) begin nfail++; $display("FAIL reset_dreq_addr_data got %h/%h exp 0", m_da, m_dd); end
        nchk++; if (m_dsz !== 3'd0 || m_dst !== 8'h00) begin nfail++; $display("FAIL reset_dreq_size_strobe got %h/%h exp 0", m_dsz, m_dst); end
        nchk++; if (m_ov !== 1'b0 || m_ord !== 64'h0) begin nfail++; $display("FAIL reset_out got %b/%h exp 0", m_ov, m_ord); end
        nchk++; if (m_omis !== 1'b0 || m_ost !== 1'b0) begin nfail++; $display("FAIL reset_flags got %b/%b exp 0", m_omis, m_ost); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        nchk++; if (m_rdy !== 1'b1) begin nfail++; $display("FAIL reset_in_ready got %b exp 1", m_rdy); end
        in_kill = 1'b1;
        #1;
        nchk++; if (m_rdy !== 1'b0) begin nfail++; $display("FAIL idle_kill_blocks got %b exp 0", m_rdy); end
        in_kill = 1'b0;
    endtask

    task automatic test_aligned_load();
        do_access(1'b0, 1'b0, 64'h1000, 2'd3, 1'b0, 64'h0, 64'h8877665544332211, 64'h0, 0, 0);
        nchk++; if (acc_rdy !== 1'b1) begin nfail++; $display("FAIL al_accept got %b exp 1", acc_rdy); end
        nchk++; if (nb != 1) begin nfail++; $display("FAIL al_beats got %0d exp 1", nb); end
        nchk++; if (b_addr[0] !== 64'h1000 || b_size[0] !== 3'd3 || b_strb[0] !== 8'h00) begin
            nfail++; $display("FAIL al_req got %h/%0d/%h exp 1000/3/00", b_addr[0], b_size[0], b_strb[0]); end
        nchk++; if (out_cyc != 2) begin nfail++; $display("FAIL al_latency got %0d exp 2", out_cyc); end
        nchk++; if (o_rdata !== 64'h8877665544332211) begin nfail++; $display("FAIL al_rdata got %h exp 8877665544332211", o_rdata); end
        nchk++; if (pulses != 1 || o_st !== 1'b0 || o_mis !== 1'b0) begin
            nfail++; $display("FAIL al_out got pulses=%0d st=%b mis=%b exp 1/0/0", pulses, o_st, o_mis); end
    endtask

    task automatic test_signed_byte();
        do_access(1'b0, 1'b0, 64'h1003, 2'd0, 1'b0, 64'h0, 64'h0000000080000000, 64'h0, 0, 0);
        nchk++; if (b_addr[0] !== 64'h1003 || b_size[0] !== 3'd0) begin
            nfail++; $display("FAIL sb_req got %h/%0d exp 1003/0", b_addr[0], b_size[0]); end
        nchk++; if (o_rdata !== 64'hFFFFFFFFFFFFFF80) begin nfail++; $display("FAIL sb_signed got %h exp ffffffffffffff80", o_rdata); end
        do_access(1'b0, 1'b0, 64'h1003, 2'd0, 1'b1, 64'h0, 64'h0000000080000000, 64'h0, 0, 0);
        nchk++; if (o_rdata !== 64'h80) begin nfail++; $display("FAIL sb_unsigned got %h exp 80", o_rdata); end
    endtask

    task automatic test_aligned_store();
        do_access(1'b0, 1'b1, 64'h2004, 2'd1, 1'b0, 64'h0000_0000_0000_BEEF, 64'h0, 64'h0, 1, 0);
        nchk++; if (nb != 1 || b_addr[0] !== 64'h2004 || b_size[0] !== 3'd1 || b_strb[0] !== 8'h30) begin
            nfail++; $display("FAIL as_req got nb=%0d %h/%0d/%h exp 1 2004/1/30", nb, b_addr[0], b_size[0], b_strb[0]); end
        nchk++; if (b_data[0] !== 64'h0000BEEF00000000) begin nfail++; $display("FAIL as_data got %h exp 0000beef00000000", b_data[0]); end
        nchk++; if (out_cyc != 3 || o_st !== 1'b1 || o_rdata !== 64'h0) begin
            nfail++; $display("FAIL as_out got cyc=%0d st=%b rd=%h exp 3/1/0", out_cyc, o_st, o_rdata); end
    endtask

    task automatic test_split_store();
        do_access(1'b0, 1'b1, 64'h1006, 2'd2, 1'b0, 64'hAABBCCDD, 64'h0, 64'h0, 0, 0);
        nchk++; if (nb != 2) begin nfail++; $display("FAIL ss_beats got %0d exp 2", nb); end
        nchk++; if (b_addr[0] !== 64'h1000 || b_strb[0] !== 8'hC0 || b_data[0] !== 64'hCCDD000000000000 || b_size[0] !== 3'd3) begin
            nfail++; $display("FAIL ss_beat0 got %h/%h/%h/%0d exp 1000/c0/ccdd000000000000/3", b_addr[0], b_strb[0], b_data[0], b_size[0]); end
        nchk++; if (b_addr[1] !== 64'h1008 || b_strb[1] !== 8'h03 || b_data[1] !== 64'hAABB) begin
            nfail++; $display("FAIL ss_beat1 got %h/%h/%h exp 1008/03/aabb", b_addr[1], b_strb[1], b_data[1]); end
        nchk++; if (pulses != 1 || o_st !== 1'b1 || out_cyc != 4) begin
            nfail++; $display("FAIL ss_out got pulses=%0d st=%b cyc=%0d exp 1/1/4", pulses, o_st, out_cyc); end
    endtask

    task automatic test_wrap_load();
        do_access(1'b0, 1'b0, 64'hFFFFFFFFFFFFFFFF, 2'd1, 1'b0, 64'h0,
                  64'hAB00000000000000, 64'h00000000000000CD, 0, 0);
        nchk++; if (nb != 2 || b_addr[0] !== 64'hFFFFFFFFFFFFFFF8 || b_addr[1] !== 64'h0) begin
            nfail++; $display("FAIL wl_addrs got nb=%0d %h/%h exp 2 fffffffffffffff8/0", nb, b_addr[0], b_addr[1]); end
        nchk++; if (b_strb[0] !== 8'h00 || b_strb[1] !== 8'h00) begin
            nfail++; $display("FAIL wl_strobe got %h/%h exp 00/00", b_strb[0], b_strb[1]); end
        nchk++; if (o_rdata !== 64'hFFFFFFFFFFFFCDAB || pulses != 1) begin
            nfail++; $display("FAIL wl_rdata got %h pulses=%0d exp ffffffffffffcdab 1", o_rdata, pulses); end
    endtask

    task automatic test_trap();
        do_access(1'b1, 1'b0, 64'h1001, 2'd1, 1'b0, 64'h0, 64'h1234, 64'h0, 0, 0);
        nchk++; if (nb != 0) begin nfail++; $display("FAIL tr_nobus got %0d beats exp 0", nb); end
        nchk++; if (out_cyc != 1 || o_mis !== 1'b1 || pulses != 1) begin
            nfail++; $display("FAIL tr_out got cyc=%0d mis=%b pulses=%0d exp 1/1/1", out_cyc, o_mis, pulses); end
        sel = 1'b0;
    endtask

    task automatic test_kill_split();
        do_access(1'b0, 1'b1, 64'h1006, 2'd2, 1'b0, 64'hAABBCCDD, 64'h0, 64'h0, 3, 2);
        nchk++; if (nb != 1) begin nfail++; $display("FAIL ks_beats got %0d exp 1", nb); end
        nchk++; if (unstable !== 1'b0) begin nfail++; $display("FAIL ks_stable got unstable=%b exp 0", unstable); end
        nchk++; if (pulses != 0) begin nfail++; $display("FAIL ks_no_out got %0d pulses exp 0", pulses); end
        nchk++; if (rdy_at[4] !== 1'b0 || rdy_at[5] !== 1'b1) begin
            nfail++; $display("FAIL ks_ready got %b/%b exp 0/1", rdy_at[4], rdy_at[5]); end
    endtask

    task automatic test_kill_done();
        do_access(1'b0, 1'b0, 64'h1000, 2'd3, 1'b0, 64'h0, 64'h55, 64'h0, 0, 2);
        nchk++; if (pulses != 0 || rdy_at[3] !== 1'b1) begin
            nfail++; $display("FAIL kd_suppress got pulses=%0d rdy=%b exp 0/1", pulses, rdy_at[3]); end
    endtask

    task automatic test_reset_mid_beat();
        @(negedge clk);
        sel = 1'b0; in_valid = 1'b1; in_write = 1'b0; in_addr = 64'h2000; in_size = 2'd3; in_kill = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        nchk++; if (m_dv !== 1'b1) begin nfail++; $display("FAIL rm_issued got %b exp 1", m_dv); end
        #1 rst = 1'b1;
        #1;
        nchk++; if (m_dv !== 1'b0) begin nfail++; $display("FAIL rm_drop got %b exp 0", m_dv); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        nchk++; if (m_rdy !== 1'b1) begin nfail++; $display("FAIL rm_ready got %b exp 1", m_rdy); end
    endtask

    initial begin
        sel = 1'b0; in_valid = 1'b0; in_kill = 1'b0; in_write = 1'b0; in_unsigned = 1'b0;
        in_addr = '0; in_wdata = '0; in_size = '0;
        dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0; dresp_data = '0;
        test_reset();
        test_aligned_load();
        test_signed_byte();
        test_aligned_store();
        test_split_store();
        test_wrap_load();
        test_trap();
        test_kill_split();
        test_kill_done();
        test_reset_mid_beat();
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
